// File: rtl/bounce_sprite_engine.sv
// Multi-ball bouncing sprite engine: per-frame position update FSM plus 2-stage pixel renderer.
// Optional shadow ring around each ball is enabled by defining BOUNCE_SHADOW_EN.
module bounce_sprite_engine #(
    parameter int unsigned NUM_BALLS = 4,
    parameter int unsigned BALL_R    = 20,
    parameter int unsigned SPEED     = 2,
    parameter int unsigned SHADOW_W  = 4,
    parameter int unsigned H_RES     = 640,
    parameter int unsigned V_RES     = 480,
    parameter logic [6*NUM_BALLS-1:0] BALL_COLORS = (6*NUM_BALLS)'(24'b110011_001111_111100_111000),
    parameter logic [5:0] SHADOW_COLOR = 6'b010101,
    parameter logic [5:0] BG_COLOR     = 6'b000010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       display_on,
    input  logic       frame_start,
    input  logic       pause,
    output logic [5:0] rgb_out,
    output logic       pix_valid,
    output logic       hit,
    output logic       busy
);

    localparam int unsigned IDX_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam logic [9:0]  X_MAX  = 10'(H_RES - 1 - BALL_R);
    localparam logic [9:0]  Y_MAX  = 10'(V_RES - 1 - BALL_R);
    localparam logic [10:0] LO_LIM = 11'(BALL_R + SPEED);
    localparam logic [20:0] R_SQ   = 21'(BALL_R * BALL_R);

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

    // Returns {dir_neg, pos}; dir_neg=1 means moving left/up.
    function automatic logic [10:0] axis_next(input logic [9:0] pos, input logic neg,
                                              input logic [9:0] hi);
        logic [10:0] w_sum;
        w_sum = {1'b0, pos} + 11'(SPEED);
        if (!neg) begin
            if (w_sum >= {1'b0, hi}) axis_next = {1'b1, hi};
            else                     axis_next = {1'b0, w_sum[9:0]};
        end else if ({1'b0, pos} <= LO_LIM) begin
            axis_next = {1'b0, 10'(BALL_R)};
        end else begin
            axis_next = {1'b1, pos - 10'(SPEED)};
        end
    endfunction

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;

    logic [9:0] r_x    [NUM_BALLS];
    logic [9:0] r_y    [NUM_BALLS];
    logic       r_xdir [NUM_BALLS];
    logic       r_ydir [NUM_BALLS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            busy    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            busy    <= (w_state_nxt != S_IDLE);
        end
    end

    // Update sequencer: one ball per cycle, frame_start ignored unless idle.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (frame_start && !pause) begin
                    w_state_nxt = S_UPDATE;
                    w_idx_nxt   = '0;
                end
            end
            S_UPDATE: begin
                if (r_idx == IDX_W'(NUM_BALLS - 1)) w_state_nxt = S_DONE;
                else                                w_idx_nxt   = r_idx + IDX_W'(1);
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_BALLS); i++) begin
                r_x[i]    <= 10'(160 + 64 * i);
                r_y[i]    <= 10'(120 + 32 * i);
                r_xdir[i] <= i[0];
                r_ydir[i] <= 1'b0;
            end
        end else if (r_state == S_UPDATE) begin
            for (int i = 0; i < int'(NUM_BALLS); i++) begin
                if (r_idx == IDX_W'(i)) begin
                    {r_xdir[i], r_x[i]} <= axis_next(r_x[i], r_xdir[i], X_MAX);
                    {r_ydir[i], r_y[i]} <= axis_next(r_y[i], r_ydir[i], Y_MAX);
                end
            end
        end
    end

    logic signed [10:0] w_ddx [NUM_BALLS];
    logic signed [10:0] w_ddy [NUM_BALLS];
    logic        [9:0]  w_adx [NUM_BALLS];
    logic        [9:0]  w_ady [NUM_BALLS];
    logic        [9:0]  r_adx [NUM_BALLS];
    logic        [9:0]  r_ady [NUM_BALLS];
    logic               r_de1;

    always_comb begin
        for (int i = 0; i < int'(NUM_BALLS); i++) begin
            w_ddx[i] = $signed({1'b0, hpos}) - $signed({1'b0, r_x[i]});
            w_ddy[i] = $signed({1'b0, vpos}) - $signed({1'b0, r_y[i]});
            w_adx[i] = w_ddx[i][10] ? 10'(-w_ddx[i]) : w_ddx[i][9:0];
            w_ady[i] = w_ddy[i][10] ? 10'(-w_ddy[i]) : w_ddy[i][9:0];
        end
    end

    // Stage 1: absolute per-axis distances, sampled against live positions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_BALLS); i++) begin
                r_adx[i] <= '0;
                r_ady[i] <= '0;
            end
            r_de1 <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_BALLS); i++) begin
                r_adx[i] <= w_adx[i];
                r_ady[i] <= w_ady[i];
            end
            r_de1 <= display_on;
        end
    end

    logic [20:0]          w_d2 [NUM_BALLS];
    logic [NUM_BALLS-1:0] w_in_ball;
`ifdef BOUNCE_SHADOW_EN
    localparam logic [20:0] RS_SQ = 21'((BALL_R + SHADOW_W) * (BALL_R + SHADOW_W));
    logic [NUM_BALLS-1:0] w_in_shadow;
`else
    logic w_unused_shadow;
    assign w_unused_shadow = ^{SHADOW_COLOR, 32'(SHADOW_W)};
`endif

    always_comb begin
        for (int i = 0; i < int'(NUM_BALLS); i++) begin
            w_d2[i]      = 21'(r_adx[i]) * 21'(r_adx[i]) + 21'(r_ady[i]) * 21'(r_ady[i]);
            w_in_ball[i] = (w_d2[i] <= R_SQ);
`ifdef BOUNCE_SHADOW_EN
            w_in_shadow[i] = (w_d2[i] <= RS_SQ);
`endif
        end
    end

    logic [5:0] w_rgb;
    logic       w_hit;

    // Priority select: lowest-index ball, then shadow, then background.
    always_comb begin
        w_rgb = BG_COLOR;
        w_hit = 1'b0;
`ifdef BOUNCE_SHADOW_EN
        if (|w_in_shadow) begin
            w_rgb = SHADOW_COLOR;
            w_hit = 1'b1;
        end
`endif
        for (int i = int'(NUM_BALLS) - 1; i >= 0; i--) begin
            if (w_in_ball[i]) begin
                w_rgb = BALL_COLORS[6*i +: 6];
                w_hit = 1'b1;
            end
        end
        if (!r_de1) begin
            w_rgb = '0;
            w_hit = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_out   <= '0;
            hit       <= 1'b0;
            pix_valid <= 1'b0;
        end else begin
            rgb_out   <= w_rgb;
            hit       <= w_hit;
            pix_valid <= r_de1;
        end
    end

endmodule
